multi_led_blinker: RTL and testbench

//  Parametrised multi-channel LED driver; successor of the single fixed-rate blinker.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_channel.sv | 124 ++++++++++++
 rtl/multi_led_blinker.sv | 81 ++++++++
 tb/tb_multi_led_blinker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the multi-channel LED blinker.
//   MODE_W  width of a channel mode field
//   mode_e  channel operating mode: OFF, ON, BLINK, BURST
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds mode/period/remaining flashes/phase and drives one LED.
// Ports:
//   CLOCK_50   in   system clock
//   reset      in   synchronous, active-high
//   tick       in   prescaler strobe; the channel advances on edges where it is high
//   wr_en      in   load new configuration (takes priority over tick)
//   wr_mode    in   new mode
//   wr_period  in   new half-period in ticks (0 behaves as 1)
//   wr_count   in   new burst flash count
//   led        out  LED drive, 1 = lit
//   busy       out  high while a burst is in progress
//
// state      | meaning
// MODE_OFF   | LED dark, phase held 0
// MODE_ON    | LED lit, phase held 0
// MODE_BLINK | LED toggles every eff_period ticks, forever
// MODE_BURST | LED toggles like BLINK; ends after remaining 1->0 toggles
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W = 16,
  parameter int CNT_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [PER_W-1:0]  wr_period,
  input  logic [CNT_W-1:0]  wr_count,
  output logic              led,
  output logic              busy
);

  mode_e             mode_q, mode_d;
  logic [PER_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [PER_W-1:0]  phase_q, phase_d;
  logic              led_q, led_d;

  logic [PER_W-1:0]  eff_period;
  logic              phase_last;

  assign eff_period = (period_q == '0) ? PER_W'(1) : period_q;
  assign phase_last = (phase_q == eff_period - PER_W'(1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      mode_q      <= MODE_OFF;
      period_q    <= '0;
      remaining_q <= '0;
      phase_q     <= '0;
      led_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      period_q    <= period_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    period_d    = period_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    led_d       = led_q;

    if (wr_en) begin
      period_d    = wr_period;
      remaining_d = wr_count;
      phase_d     = '0;
      case (mode_e'(wr_mode))
        MODE_OFF: begin
          mode_d = MODE_OFF;
          led_d  = 1'b0;
        end
        MODE_ON: begin
          mode_d = MODE_ON;
          led_d  = 1'b1;
        end
        MODE_BLINK: begin
          mode_d = MODE_BLINK;
          led_d  = 1'b1;
        end
        default: begin
          // A zero-length burst is finished before it starts.
          if (wr_count != '0) begin
            mode_d = MODE_BURST;
            led_d  = 1'b1;
          end else begin
            mode_d = MODE_OFF;
            led_d  = 1'b0;
          end
        end
      endcase
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK, MODE_BURST: begin
          if (phase_last) begin
            phase_d = '0;
            led_d   = ~led_q;
            // A flash completes on the falling toggle; the last one ends the burst.
            if (mode_q == MODE_BURST && led_q && remaining_q != '0) begin
              remaining_d = remaining_q - CNT_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                mode_d = MODE_OFF;
                led_d  = 1'b0;
              end
            end
          end else begin
            phase_d = phase_q + PER_W'(1);
          end
        end
        default: phase_d = '0;
      endcase
    end
  end

  assign led  = led_q;
  assign busy = (mode_q == MODE_BURST);

endmodule

// File: rtl/multi_led_blinker.sv
// Multi-channel LED driver with a shared tick prescaler.
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   synchronous, active-high
//   cfg_we      in   one-cycle write strobe
//   cfg_ch      in   target channel; writes to channels >= NUM_CH are dropped
//   cfg_mode    in   00 OFF, 01 ON, 10 BLINK, 11 BURST
//   cfg_period  in   half-period in ticks (0 behaves as 1)
//   cfg_count   in   burst flash count
//   LED         out  per-channel LED drive, 1 = lit
//   busy        out  per-channel burst-in-progress flag
//   tick        out  one-cycle strobe every DIV clocks
module multi_led_blinker
  import led_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH  = 4,
  parameter int PER_W   = 16,
  parameter int CNT_W   = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] busy,
  output logic              tick
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             ch_valid;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  // tick is registered, so it is high in the cycle after the count sat at DIV-1.
  always_comb begin
    tick_d  = (presc_q == PRE_W'(DIV - 1));
    presc_d = tick_d ? '0 : presc_q + PRE_W'(1);
  end

  assign tick     = tick_q;
  assign ch_valid = (int'(cfg_ch) < NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_en;
    assign wr_en = cfg_we && ch_valid && (int'(cfg_ch) == g);

    led_channel #(
      .PER_W (PER_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .tick      (tick_q),
      .wr_en     (wr_en),
      .wr_mode   (cfg_mode),
      .wr_period (cfg_period),
      .wr_count  (cfg_count),
      .led       (LED[g]),
      .busy      (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_led_blinker.sv
module tb_multi_led_blinker;
  import led_pkg::*;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NUM_CH  = 4;
  localparam int PER_W   = 16;
  localparam int CNT_W   = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset    = 1'b1;
  logic             cfg_we   = 1'b0;
  logic [1:0]       cfg_ch   = '0;
  logic [1:0]       cfg_mode = '0;
  logic [PER_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_count  = '0;
  logic [3:0]       LED, busy;
  logic             tick;
  logic [2:0]       led3, busy3;
  logic             tick3;

  always #5 CLOCK_50 = ~CLOCK_50;

  multi_led_blinker #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH), .PER_W(PER_W), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .LED(LED), .busy(busy), .tick(tick)
  );

  // Three-channel instance: cfg_ch=3 is out of range here and must be dropped.
  multi_led_blinker #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(3), .PER_W(PER_W), .CNT_W(CNT_W)
  ) dut3 (
    .CLOCK_50(CLOCK_50), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_count(cfg_count),
    .LED(led3), .busy(busy3), .tick(tick3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, the configuration written and the number of
  // ticks seen since that write; LED/busy follow in closed form.
  int k;
  int m_mode [NUM_CH];
  int m_eff  [NUM_CH];
  int m_cnt  [NUM_CH];
  int m_n    [NUM_CH];
  logic [3:0] exp_led, exp_busy;
  logic       exp_tick;

  function automatic void model_reset();
    k = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = int'(MODE_OFF);
      m_eff[c]  = 1;
      m_cnt[c]  = 0;
      m_n[c]    = 0;
    end
  endfunction

  function automatic void model_edge();
    bit adv;
    if (reset) begin
      model_reset();
      return;
    end
    adv = (k > 0) && (k % DIV == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_we && int'(cfg_ch) == c) begin
        m_mode[c] = int'(cfg_mode);
        if (m_mode[c] == int'(MODE_BURST) && cfg_count == 0) m_mode[c] = int'(MODE_OFF);
        m_eff[c]  = (cfg_period == 0) ? 1 : int'(cfg_period);
        m_cnt[c]  = int'(cfg_count);
        m_n[c]    = 0;
      end else if (adv) begin
        m_n[c] = m_n[c] + 1;
      end
    end
    k = k + 1;
  endfunction

  function automatic void model_outputs();
    int dur;
    exp_tick = (k > 0) && (k % DIV == 0);
    for (int c = 0; c < NUM_CH; c++) begin
      exp_led[c]  = 1'b0;
      exp_busy[c] = 1'b0;
      if (m_mode[c] == int'(MODE_ON)) begin
        exp_led[c] = 1'b1;
      end else if (m_mode[c] == int'(MODE_BLINK)) begin
        exp_led[c] = ((m_n[c] / m_eff[c]) % 2 == 0);
      end else if (m_mode[c] == int'(MODE_BURST)) begin
        dur = (2 * m_cnt[c] - 1) * m_eff[c];
        if (m_n[c] < dur) begin
          exp_led[c]  = ((m_n[c] / m_eff[c]) % 2 == 0);
          exp_busy[c] = 1'b1;
        end
      end
    end
  endfunction

  task automatic edge_and_check();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    model_outputs();
    checks++;
    assert (LED === exp_led)
      else begin errors++; $error("FAIL led k=%0d got %b expected %b", k, LED, exp_led); end
    checks++;
    assert (busy === exp_busy)
      else begin errors++; $error("FAIL busy k=%0d got %b expected %b", k, busy, exp_busy); end
    checks++;
    assert (tick === exp_tick)
      else begin errors++; $error("FAIL tick k=%0d got %b expected %b", k, tick, exp_tick); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) edge_and_check();
  endtask

  task automatic cyc(input int ch, input int mode, input int per, input int cnt);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = PER_W'(per);
    cfg_count  = CNT_W'(cnt);
    edge_and_check();
    cfg_we = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  // Advance until the next edge is one on which the channels see tick.
  task automatic wait_adv();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (k > 0 && k % DIV == 0) begin
        found = 1'b1;
        break;
      end
      edge_and_check();
    end
    checks++;
    assert (found)
      else begin errors++; $error("FAIL wait_adv got timeout expected tick edge"); end
  endtask

  initial begin
    model_reset();

    // 1: reset, then free-running tick
    reset_cycles(3);
    idle(31);

    // 2: ch0 ON
    cyc(0, int'(MODE_ON), 0, 0);
    idle(50);

    // 3: ch1 BLINK period 3, then period 0
    cyc(1, int'(MODE_BLINK), 3, 0);
    idle(130);
    cyc(1, int'(MODE_BLINK), 0, 0);
    idle(40);

    // 4: ch2 BURST count 2 period 1
    cyc(2, int'(MODE_BURST), 1, 2);
    idle(50);

    // 5: reset mid-burst, out-of-range channel, zero-length burst
    cyc(3, int'(MODE_BURST), 2, 3);
    idle(25);
    reset_cycles(1);
    cyc(3, int'(MODE_ON), 0, 0);
    checks++;
    assert (led3 === 3'b000)
      else begin errors++; $error("FAIL oor_led got %b expected %b", led3, 3'b000); end
    checks++;
    assert (busy3 === 3'b000)
      else begin errors++; $error("FAIL oor_busy got %b expected %b", busy3, 3'b000); end
    cyc(2, int'(MODE_ON), 0, 0);
    checks++;
    assert (led3 === 3'b100)
      else begin errors++; $error("FAIL inrange_led got %b expected %b", led3, 3'b100); end
    cyc(0, int'(MODE_BURST), 2, 0);
    idle(20);

    // 6: write ch1 on the same edge as a tick while ch0 blinks
    cyc(0, int'(MODE_BLINK), 1, 0);
    wait_adv();
    edge_and_check();
    wait_adv();
    cyc(1, int'(MODE_BLINK), 2, 0);
    idle(60);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        cyc(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end else if (r == 6 && $urandom_range(0, 9) == 0) begin
        reset_cycles(1);
      end else begin
        edge_and_check();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
